// File: rtl/digger_pkg.sv
// digger_pkg: tile codes, direction codes and grid geometry shared by the digger game blocks.
package digger_pkg;
    localparam int GRID_W = 15;
    localparam int GRID_H = 10;
    localparam logic [3:0] T_BLANK   = 4'd0;
    localparam logic [3:0] T_DIG_L   = 4'd1;
    localparam logic [3:0] T_DIG_R   = 4'd2;
    localparam logic [3:0] T_DIG_U   = 4'd3;
    localparam logic [3:0] T_DIG_D   = 4'd4;
    localparam logic [3:0] T_BULLET  = 4'd5;
    localparam logic [3:0] T_GOB_LO  = 4'd6;
    localparam logic [3:0] T_GOB_HI  = 4'd8;
    localparam logic [3:0] T_DIAMOND = 4'd9;
    localparam logic [3:0] T_BAG_LO  = 4'd10;
    localparam logic [3:0] T_WALL    = 4'd15;
    localparam logic [2:0] D_NONE  = 3'd0;
    localparam logic [2:0] D_LEFT  = 3'd1;
    localparam logic [2:0] D_RIGHT = 3'd2;
    localparam logic [2:0] D_UP    = 3'd3;
    localparam logic [2:0] D_DOWN  = 3'd4;

    function automatic logic [7:0] cell_addr(input logic [3:0] row, input logic [3:0] col);
        return {4'd0, row} * 8'(GRID_W) + {4'd0, col};
    endfunction
endpackage

// File: rtl/digger_map_ctl.sv
// digger_map_ctl: owns tile RAM port A; scans the map after reset, then moves the digger tile on each tick.
module digger_map_ctl #(
    parameter int GRID_W = 15,
    parameter int GRID_H = 10,
    parameter int RD_LAT = 1
) (
    input  logic       clk100m,
    input  logic       rst,
    input  logic       move_tick,
    input  logic [2:0] dmov,
    input  logic [3:0] vgaram_douta,
    output logic       vgaram_we,
    output logic [7:0] vgaram_addra,
    output logic [3:0] vgaram_dina,
    output logic [3:0] dig_col,
    output logic [3:0] dig_row,
    output logic       score_inc,
    output logic [7:0] diamonds_left,
    output logic       game_over,
    output logic       level_clear,
    output logic       busy
);
    import digger_pkg::*;

    localparam int CELLS = GRID_W * GRID_H;
    localparam logic [7:0] FIX_ADDR = 8'((GRID_H - 1) * GRID_W + GRID_W / 2);
    localparam logic [2:0] S_SCAN = 3'd0, S_FIX = 3'd1, S_IDLE = 3'd2, S_TGT_RD = 3'd3,
                           S_DECIDE = 3'd4, S_WR_NEW = 3'd5, S_WR_OLD = 3'd6, S_TURN = 3'd7;

    logic [2:0] state_q, state_d, dir_q, dir_d;
    logic [7:0] cnt_q, cnt_d, dl_q, dl_d;
    logic [3:0] chk_col_q, chk_col_d, chk_row_q, chk_row_d, col_q, col_d, row_q, row_d;
    logic       found_q, found_d, pick_q, pick_d, go_q, go_d, lc_q, lc_d;
    logic [3:0] tgt_col, tgt_row;
    logic [7:0] cur_addr, tgt_addr;
    logic       chk, off_grid, step_ok, is_gob;

    assign cur_addr = {4'd0, row_q} * 8'(GRID_W) + {4'd0, col_q};
    assign tgt_col  = dir_q == D_LEFT ? col_q - 4'd1 : dir_q == D_RIGHT ? col_q + 4'd1 : col_q;
    assign tgt_row  = dir_q == D_UP ? row_q - 4'd1 : dir_q == D_DOWN ? row_q + 4'd1 : row_q;
    assign tgt_addr = {4'd0, tgt_row} * 8'(GRID_W) + {4'd0, tgt_col};
    assign chk      = state_q == S_SCAN && cnt_q >= 8'(RD_LAT);
    assign off_grid = (dmov == D_LEFT && col_q == 4'd0) || (dmov == D_RIGHT && col_q == 4'(GRID_W - 1)) ||
                      (dmov == D_UP && row_q == 4'd0) || (dmov == D_DOWN && row_q == 4'(GRID_H - 1));
    assign is_gob   = vgaram_douta inside {[T_GOB_LO:T_GOB_HI]};
    assign step_ok  = vgaram_douta == T_BLANK || vgaram_douta == T_BULLET || vgaram_douta == T_DIAMOND || is_gob;

    assign vgaram_we    = (state_q == S_FIX && !found_q) || state_q == S_WR_NEW || state_q == S_WR_OLD || state_q == S_TURN;
    assign vgaram_addra = state_q == S_SCAN ? (cnt_q < 8'(CELLS) ? cnt_q : 8'(CELLS - 1)) :
                          state_q == S_FIX ? FIX_ADDR :
                          (state_q == S_TGT_RD || state_q == S_DECIDE || state_q == S_WR_NEW) ? tgt_addr : cur_addr;
    assign vgaram_dina  = state_q == S_FIX ? T_DIG_U :
                          (state_q == S_WR_NEW || state_q == S_TURN) ? {1'b0, dir_q} : T_BLANK;
    assign dig_col       = col_q;
    assign dig_row       = row_q;
    assign score_inc     = state_q == S_WR_OLD && pick_q;
    assign diamonds_left = dl_q;
    assign game_over     = go_q;
    assign level_clear   = lc_q;
    assign busy          = state_q != S_IDLE;

    always_comb begin
        state_d = state_q; cnt_d = cnt_q; dl_d = dl_q; dir_d = dir_q;
        chk_col_d = chk_col_q; chk_row_d = chk_row_q; col_d = col_q; row_d = row_q;
        found_d = found_q; pick_d = pick_q; go_d = go_q; lc_d = lc_q;
        case (state_q)
            S_SCAN: begin
                cnt_d = cnt_q + 8'd1;
                if (chk) begin
                    chk_col_d = chk_col_q == 4'(GRID_W - 1) ? 4'd0 : chk_col_q + 4'd1;
                    chk_row_d = chk_col_q == 4'(GRID_W - 1) ? chk_row_q + 4'd1 : chk_row_q;
                    dl_d = vgaram_douta == T_DIAMOND ? dl_q + 8'd1 : dl_q;
                    if (!found_q && vgaram_douta inside {[T_DIG_L:T_DIG_D]}) begin
                        found_d = 1'b1; col_d = chk_col_q; row_d = chk_row_q;
                    end
                end
                if (cnt_q == 8'(CELLS - 1 + RD_LAT)) state_d = S_FIX;
            end
            S_FIX: begin
                if (!found_q) begin
                    col_d = 4'(GRID_W / 2); row_d = 4'(GRID_H - 1);
                end
                state_d = S_IDLE;
            end
            S_IDLE: if (move_tick && !go_q && !lc_q && dmov inside {[D_LEFT:D_DOWN]}) begin
                dir_d = dmov; cnt_d = 8'd1;
                state_d = off_grid ? S_TURN : S_TGT_RD;
            end
            S_TGT_RD: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == 8'(RD_LAT)) state_d = S_DECIDE;
            end
            S_DECIDE: begin
                pick_d = vgaram_douta == T_DIAMOND;
                go_d = go_q || is_gob;
                state_d = step_ok ? S_WR_NEW : S_TURN;
            end
            S_WR_NEW: state_d = S_WR_OLD;
            S_WR_OLD: begin
                col_d = tgt_col; row_d = tgt_row; pick_d = 1'b0;
                // Decrement saturates at 0; a pickup that leaves nothing clears the level.
                if (pick_q) begin
                    dl_d = dl_q == 8'd0 ? 8'd0 : dl_q - 8'd1;
                    lc_d = lc_q || dl_q <= 8'd1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk100m or posedge rst) begin
        if (rst) begin
            state_q <= S_SCAN; cnt_q <= 8'd0; dl_q <= 8'd0; dir_q <= D_NONE;
            chk_col_q <= 4'd0; chk_row_q <= 4'd0; col_q <= 4'd0; row_q <= 4'd0;
            found_q <= 1'b0; pick_q <= 1'b0; go_q <= 1'b0; lc_q <= 1'b0;
        end else begin
            state_q <= state_d; cnt_q <= cnt_d; dl_q <= dl_d; dir_q <= dir_d;
            chk_col_q <= chk_col_d; chk_row_q <= chk_row_d; col_q <= col_d; row_q <= row_d;
            found_q <= found_d; pick_q <= pick_d; go_q <= go_d; lc_q <= lc_d;
        end
    end
endmodule

// File: doc/digger_map_ctl.md
# digger_map_ctl

Game-side map controller that owns write port A of the 15x10 tile RAM (`bg_ram`) that the pixel renderer reads on port B. On reset it scans the map to locate the digger and count diamonds. On each movement tick it performs a read-check-write move of the digger tile: it handles walls, money bags, goblins and diamond pickup, and reports score and end-of-game events to the game control logic.

## Interface
Parameters:
- `GRID_W`, 15: columns; cell address = row*GRID_W + col.
- `GRID_H`, 10: rows; 150 cells, addresses 0..149.
- `RD_LAT`, 1: tile RAM port-A read latency in cycles (1 or 2).

Ports:
- `clk100m`  in  1  system clock; same clock as RAM port A.
- `rst`  in  1  asynchronous, active-high reset.
- `move_tick`  in  1  single-cycle move request, synchronous to `clk100m`.
- `dmov`  in  3  direction: 0 none, 1 left, 2 right, 3 up, 4 down, 5..7 none.
- `vgaram_douta`  in  4  tile code read from port A.
- `vgaram_we`  out  1  port-A write enable.
- `vgaram_addra`  out  8  port-A address.
- `vgaram_dina`  out  4  port-A write data.
- `dig_col`  out  4  digger column, 0..14.
- `dig_row`  out  4  digger row, 0..9.
- `score_inc`  out  1  one-cycle pulse per diamond collected.
- `diamonds_left`  out  8  diamonds remaining on the map.
- `game_over`  out  1  sticky; set when the digger moves onto a goblin.
- `level_clear`  out  1  sticky; set when `diamonds_left` reaches 0 after a pickup.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Tile codes: 0 blank; 1/2/3/4 digger facing L/R/U/D; 5 bullet; 6-8 goblin; 9 diamond; 10-14 money bag; 15 wall.
- Reset values: `vgaram_we`=0, `vgaram_addra`=0, `vgaram_dina`=0, `dig_col`=0, `dig_row`=0, `score_inc`=0, `diamonds_left`=0, `game_over`=0, `level_clear`=0, `busy`=1. The FSM enters SCAN.
- SCAN: issues reads of addresses 0..149, one per cycle, with `we`=0. Each returned code is checked RD_LAT cycles after its address was issued.
  - Code 9 increments `diamonds_left`.
  - The first code in 1..4 sets `dig_col`/`dig_row`. Later digger codes are ignored.
- FIX: entered after the last check. If no digger was found, writes code 3 to cell 142 (row 9, col 7) and sets the position to that cell. Then goes to IDLE.
- IDLE: `move_tick` is acted on only if `game_over`=0, `level_clear`=0 and `dmov` is 1..4. A tick that arrives in any non-IDLE state is dropped (not queued).
- Target cell: neighbour of the current cell in direction `dmov`.
  - If the target is off-grid (col 0 going left, col 14 going right, row 0 going up, row 9 going down): TURN only.
  - Otherwise: TGT_RD, then DECIDE on the returned code.
- DECIDE:
  - Code 0 or 5: STEP.
  - Code 9: STEP, plus one-cycle `score_inc` and `diamonds_left` decrement. If the decrement result is 0, set `level_clear`.
  - Code 6-8: STEP and set `game_over`.
  - Code 1-4, 10-15: TURN.
- STEP: WR_NEW writes the facing code (equal to `dmov`) to the target; WR_OLD writes 0 to the old cell. The position updates in the WR_OLD cycle.
- TURN: single write of the facing code to the current cell. Position unchanged.
- `diamonds_left` saturates at 0 and never wraps.
- Asynchronous reset in any state abandons the move immediately (a partial STEP is possible) and re-enters SCAN.

## Timing
- Port-A read issued in cycle N: `vgaram_douta` is sampled at the clock edge ending cycle N+RD_LAT.
- STEP with `move_tick` sampled high in IDLE at edge 0 (RD_LAT=1):
  - Cycle 1: TGT_RD, target address driven, `we`=0.
  - Cycle 2: DECIDE.
  - Cycle 3: WR_NEW, `we`=1.
  - Cycle 4: WR_OLD, `we`=1; `score_inc` high this cycle when a diamond is taken.
  - Cycle 5: IDLE, `busy`=0.
- TURN: write in cycle 1 (off-grid) or cycle 3 (blocked); IDLE the cycle after.
- SCAN duration: 150 + RD_LAT cycles, plus 1 FIX cycle.
- Each write cycle has `we` high for exactly one cycle. `vgaram_dina` and `vgaram_addra` are valid in that same cycle.

## Structure
- Shared package `digger_pkg`:
  - Tile-code constants, direction codes, GRID_W, GRID_H.
  - Function `cell_addr(row,col)` returning an 8-bit address.
- No sub-module. The FSM, the scan counter and the position registers live in this block.

## Test plan
- Map with digger code 4 at cell 22 and diamonds at cells 5, 60, 149 → after scan: `dig_col`=7, `dig_row`=1, `diamonds_left`=3, `busy` low at cycle 152.
- Digger at (7,1), blank target at (8,1), `dmov`=2 tick → cycle 3 writes 2 to addr 23, cycle 4 writes 0 to addr 22, `dig_col`=8.
- Target holds 9 (last diamond) → `score_inc` one cycle in WR_OLD, `diamonds_left`=0, `level_clear`=1, later ticks ignored.
- Wall (15) above the digger, `dmov`=3 → single write of 3 to the current cell, position unchanged. Same single write for a col-0 `dmov`=1 tick.
- Target is goblin (7) → STEP completes and `game_over`=1. A second tick while busy is dropped.
- `rst` asserted in WR_NEW → all outputs take reset values asynchronously and the rescan finds the partial state correctly.
